// File: rtl/sketch_pkg.sv
// Shared definitions for the etch-a-sketch frame-buffer write path.
package sketch_pkg;

  localparam int BMP_BITS  = 7;
  localparam int ADDR_BITS = 14;
  localparam int RGB_BITS  = 3;

  localparam logic [BMP_BITS-1:0] BMP_MAX = 7'd127;

  typedef enum logic [1:0] {
    IDLE,
    PLOT,
    CLEAR
  } state_t;

endpackage

// File: rtl/sketch_cursor.sv
// Cursor position registers with saturating single-pixel steps.
module sketch_cursor
  import sketch_pkg::*;
#(
  parameter int HOME_X = 64,
  parameter int HOME_Y = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                step,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  output logic [BMP_BITS-1:0] dot_x,
  output logic [BMP_BITS-1:0] dot_y,
  output logic [BMP_BITS-1:0] nxt_x,
  output logic [BMP_BITS-1:0] nxt_y
);

  // Candidate position for the next step; opposing buttons cancel, edges clamp.
  always_comb begin
    nxt_x = dot_x;
    nxt_y = dot_y;
    if (btn_left && !btn_right) begin
      if (dot_x != '0) nxt_x = dot_x - 1'b1;
    end else if (btn_right && !btn_left) begin
      if (dot_x != BMP_MAX) nxt_x = dot_x + 1'b1;
    end
    if (btn_up && !btn_down) begin
      if (dot_y != '0) nxt_y = dot_y - 1'b1;
    end else if (btn_down && !btn_up) begin
      if (dot_y != BMP_MAX) nxt_y = dot_y + 1'b1;
    end
  end

  // Position register: re-homes on reset, moves only on a step strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dot_x <= BMP_BITS'(HOME_X);
      dot_y <= BMP_BITS'(HOME_Y);
    end else if (step) begin
      dot_x <= nxt_x;
      dot_y <= nxt_y;
    end
  end

endmodule

// File: rtl/sketch_wr_ctrl.sv
// Bitmap RAM write-port controller: arbitrates cursor plots and full-screen clears.
module sketch_wr_ctrl
  import sketch_pkg::*;
#(
  parameter int                  MOVE_DIV    = 4,
  parameter int                  HOME_X      = 64,
  parameter int                  HOME_Y      = 64,
  parameter logic [RGB_BITS-1:0] CLEAR_COLOR = 3'b000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 refr_tick,
  input  logic                 btn_up,
  input  logic                 btn_down,
  input  logic                 btn_left,
  input  logic                 btn_right,
  input  logic                 btn_clr,
  input  logic [RGB_BITS-1:0]  sw,
  output logic                 we,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [RGB_BITS-1:0]  wr_data,
  output logic [BMP_BITS-1:0]  dot_x,
  output logic [BMP_BITS-1:0]  dot_y,
  output logic                 busy
);

  localparam int                    FCNT_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [FCNT_W-1:0]     FCNT_LAST = FCNT_W'(MOVE_DIV - 1);
  localparam logic [ADDR_BITS-1:0]  ADDR_LAST = '1;

  state_t                state, state_nxt;
  logic [FCNT_W-1:0]     fcnt, fcnt_nxt;
  logic [ADDR_BITS-1:0]  clr_cnt, clr_cnt_nxt;
  logic                  clr_pend, clr_pend_nxt;
  logic                  we_nxt, busy_nxt, step;
  logic [ADDR_BITS-1:0]  wr_addr_nxt;
  logic [RGB_BITS-1:0]   wr_data_nxt;
  logic [BMP_BITS-1:0]   nxt_x, nxt_y;
  logic                  any_btn;

  assign any_btn = btn_up | btn_down | btn_left | btn_right;

  sketch_cursor #(
    .HOME_X (HOME_X),
    .HOME_Y (HOME_Y)
  ) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .dot_x     (dot_x),
    .dot_y     (dot_y),
    .nxt_x     (nxt_x),
    .nxt_y     (nxt_y)
  );

  // Next state plus the next value of every registered output; a pending clear
  // outranks a same-cycle step so the step is dropped and fcnt left alone.
  always_comb begin
    state_nxt    = state;
    fcnt_nxt     = fcnt;
    clr_cnt_nxt  = clr_cnt;
    clr_pend_nxt = clr_pend;
    we_nxt       = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    busy_nxt     = 1'b0;
    step         = 1'b0;

    if (btn_clr && state != CLEAR) clr_pend_nxt = 1'b1;

    unique case (state)
      IDLE: begin
        if (clr_pend || btn_clr) begin
          state_nxt    = CLEAR;
          clr_cnt_nxt  = '0;
          clr_pend_nxt = 1'b0;
          we_nxt       = 1'b1;
          wr_addr_nxt  = '0;
          wr_data_nxt  = CLEAR_COLOR;
          busy_nxt     = 1'b1;
        end else if (refr_tick) begin
          if (fcnt == FCNT_LAST) begin
            fcnt_nxt = '0;
            if (any_btn) begin
              step        = 1'b1;
              state_nxt   = PLOT;
              we_nxt      = 1'b1;
              wr_addr_nxt = {nxt_y, nxt_x};
              wr_data_nxt = sw;
            end
          end else begin
            fcnt_nxt = fcnt + 1'b1;
          end
        end
      end
      PLOT: begin
        state_nxt = IDLE;
      end
      CLEAR: begin
        we_nxt = 1'b1;
        if (clr_cnt == ADDR_LAST) begin
          // Hand straight over to a cursor redraw at the unchanged position.
          state_nxt   = PLOT;
          fcnt_nxt    = '0;
          wr_addr_nxt = {dot_y, dot_x};
          wr_data_nxt = sw;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
          wr_addr_nxt = clr_cnt + 1'b1;
          wr_data_nxt = CLEAR_COLOR;
          busy_nxt    = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, counters and registered RAM-side outputs; reset aborts any clear at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fcnt     <= '0;
      clr_cnt  <= '0;
      clr_pend <= 1'b0;
      we       <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      fcnt     <= fcnt_nxt;
      clr_cnt  <= clr_cnt_nxt;
      clr_pend <= clr_pend_nxt;
      we       <= we_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule
